s2p_lane_ctrl: RTL and testbench
================================

S2P_LANE_CTRL -- requirements
Module: s2p_lane_ctrl

Interface
REQ-001 The block SHALL have parameter COM, default 8'hBC: alignment symbol carried on lane 0 as byte 0 of every frame.
REQ-002 The block SHALL have parameter FRAME_LEN, default 16: bytes per frame, legal range 2..256.
REQ-003 The block SHALL have parameter LOCK_CNT, default 4: consecutive good COMs required to declare lock, range 1..15.
REQ-004 The block SHALL have parameter LOSS_CNT, default 4: consecutive missing COMs required to drop lock, range 1..15.
REQ-005 The block SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-007 The block SHALL have port IN_ENB  input  1  bit-slot enable; when low, the cycle is not a bit slot.
REQ-008 The block SHALL have port IN_DIR  input  1  shift direction, 0 = left shift, 1 = right shift.
REQ-009 The block SHALL have port IN_LANE  input  4  serial bit per lane, bit n = lane n.
REQ-010 The block SHALL have ports OUT_LANE3, OUT_LANE2, OUT_LANE1, OUT_LANE0  output  8 each  last completed byte per lane.
REQ-011 The block SHALL have port OUT_VALID  output  1  one-cycle strobe: new bytes present on OUT_LANEx.
REQ-012 The block SHALL have port OUT_SOF  output  1  qualifies OUT_VALID; the bytes are frame byte 0.
REQ-013 The block SHALL have port OUT_LOCK  output  1  high only in state LOCKED.
REQ-014 The block SHALL have port OUT_STATE  output  2  encoding HUNT = 0, VERIFY = 1, LOCKED = 2.

Function
REQ-015 When IN_ENB = 1, the block SHALL shift each lane's 8-bit register by one position per cycle. IN_DIR = 0: shift left, new bit into bit 0. IN_DIR = 1: shift right, new bit into bit 7.
REQ-016 When IN_ENB = 0, the shift registers, bit counter, byte counter, good/bad counters and state SHALL hold, and OUT_VALID/OUT_SOF SHALL be 0.
REQ-017 In HUNT, in each enabled cycle, the block SHALL compare the post-shift lane 0 value to COM. On a match it SHALL load bit_cnt = 0, byte_cnt = 0, good = 1, go to VERIFY (or to LOCKED if LOCK_CNT = 1), and produce no OUT_VALID.
REQ-018 Outside HUNT, bit_cnt SHALL count enabled cycles 0..7. Any enabled cycle with bit_cnt = 7 completes a byte: bit_cnt wraps to 0, and byte_cnt advances modulo FRAME_LEN.
REQ-019 A completed byte whose new byte_cnt = 0 SHALL be a frame-start byte; the block SHALL check its lane 0 value against COM.
REQ-020 In VERIFY, a frame-start match SHALL increment good; when good reaches LOCK_CNT, the state SHALL become LOCKED. A mismatch SHALL return the state to HUNT, with good = 0.
REQ-021 In LOCKED, a frame-start match SHALL clear bad, and a mismatch SHALL increment bad. When bad reaches LOSS_CNT, the state SHALL become HUNT and OUT_LOCK SHALL fall the next cycle.
REQ-022 In LOCKED, on each completed byte, the block SHALL register all four post-shift lane values to OUT_LANEx and pulse OUT_VALID high for exactly the following cycle. OUT_SOF SHALL be high with it for frame-start bytes, including a mismatched frame-start byte that does not yet drop lock.
REQ-023 The completed byte that causes the transition out of LOCKED SHALL NOT produce OUT_VALID.
REQ-024 The block SHALL assert OUT_VALID only in LOCKED. OUT_LANEx SHALL hold their value between strobes, including across loss of lock.
REQ-025 The block SHALL sample IN_DIR every enabled cycle. A change of IN_DIR mid-byte SHALL take effect on the next shift and SHALL NOT reset counters.
REQ-026 Counter widths: bit_cnt 3 bits; byte_cnt ceil(log2(FRAME_LEN)) bits, minimum 1; good and bad 4 bits each, saturating, never wrapping.
REQ-027 OUT_STATE and OUT_LOCK SHALL be registered and SHALL reflect the state after the most recent clock edge.

Reset
REQ-028 While RESET = 0, regardless of CLK: state = HUNT, all shift registers and counters = 0, OUT_LANE0..3 = 8'h00, OUT_VALID = 0, OUT_SOF = 0, OUT_LOCK = 0, OUT_STATE = 0.
REQ-029 Reset asserted mid-byte or mid-frame SHALL discard all partial data. After RESET rises, the first enabled CLK edge SHALL be treated as a HUNT bit slot.

Verification
REQ-030 Reset/idle: RESET = 0 with random IN_LANE toggling -> all outputs 0 and OUT_STATE = 0 throughout; after release with IN_ENB = 0 -> outputs stay 0.
REQ-031 Acquire lock: defaults, IN_DIR = 0, lane 0 sends COM (8'hBC, MSB first) every 16 bytes, lanes 1..3 send 8'h11/8'h22/8'h33 -> OUT_STATE 0→1 after the first COM, 1→2 after the 4th COM; first OUT_VALID carries OUT_SOF = 1, OUT_LANE0 = 8'hBC, OUT_LANE1..3 = 8'h11/8'h22/8'h33; then 15 strobes follow, each 8 enabled cycles apart, with OUT_SOF = 0.
REQ-032 False COM in VERIFY: one COM, then 8'h00 at the next frame start -> return to HUNT; no OUT_VALID is ever asserted.
REQ-033 Loss of lock: in LOCKED, replace COM with 8'h3C in 4 consecutive frames -> OUT_SOF strobes on the first 3; OUT_LOCK drops the cycle after the 4th frame start; that byte has no OUT_VALID. A test replacing only 3, then restoring COM, stays locked with bad cleared.
REQ-034 Enable gating and direction: locked stream with IN_ENB low for 5 cycles inside a byte -> byte completes 5 cycles later with correct data. IN_DIR = 1 with lane 0 sending 8'hBC LSB first -> identical lock sequence.
REQ-035 Reset mid-operation: RESET pulsed low while LOCKED, at bit 4 of a byte -> outputs clear asynchronously; relock follows REQ-031 timing from the next COM.

Source files
------------

// File: rtl/s2p_lane_ctrl.sv
// s2p_lane_ctrl: four-lane serial-to-parallel converter. Lane 0 carries a COM
// symbol as byte 0 of every frame; a HUNT/VERIFY/LOCKED tracker aligns to it
// and publishes completed bytes of all four lanes only while locked.
module s2p_lane_ctrl #(
  parameter logic [7:0]  COM       = 8'hBC,
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned LOCK_CNT  = 4,
  parameter int unsigned LOSS_CNT  = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       IN_ENB,
  input  logic       IN_DIR,
  input  logic [3:0] IN_LANE,
  output logic [7:0] OUT_LANE3,
  output logic [7:0] OUT_LANE2,
  output logic [7:0] OUT_LANE1,
  output logic [7:0] OUT_LANE0,
  output logic       OUT_VALID,
  output logic       OUT_SOF,
  output logic       OUT_LOCK,
  output logic [1:0] OUT_STATE
);

  localparam int unsigned      ByteW    = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam logic [ByteW-1:0] LastByte = ByteW'(FRAME_LEN - 1);
  localparam logic [3:0]       LockTh   = 4'(LOCK_CNT);
  localparam logic [3:0]       LossTh   = 4'(LOSS_CNT);

  typedef enum logic [1:0] {
    StHunt   = 2'd0,
    StVerify = 2'd1,
    StLocked = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [3:0][7:0]  sr_q, sr_d, sr_shift;
  logic [3:0][7:0]  lane_q, lane_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [ByteW-1:0] byte_cnt_q, byte_cnt_d, byte_next;
  logic [3:0]       good_q, good_d, good_inc;
  logic [3:0]       bad_q, bad_d, bad_inc;
  logic             valid_q, valid_d;
  logic             sof_q, sof_d;
  logic             lock_q;
  logic             byte_done, frame_start, com_hit;

  // Post-shift view of every lane for the current bit slot.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      sr_shift[i] = IN_DIR ? {IN_LANE[i], sr_q[i][7:1]} : {sr_q[i][6:0], IN_LANE[i]};
    end
  end

  // Byte/frame boundary decode and saturating counter increments.
  always_comb begin
    byte_done   = (bit_cnt_q == 3'd7);
    byte_next   = (byte_cnt_q == LastByte) ? '0 : byte_cnt_q + ByteW'(1);
    frame_start = byte_done && (byte_next == '0);
    com_hit     = (sr_shift[0] == COM);
    good_inc    = (good_q == 4'hF) ? good_q : good_q + 4'd1;
    bad_inc     = (bad_q == 4'hF) ? bad_q : bad_q + 4'd1;
  end

  // Alignment FSM next state, counters and output strobe generation.
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    good_d     = good_q;
    bad_d      = bad_q;
    lane_d     = lane_q;
    valid_d    = 1'b0;
    sof_d      = 1'b0;
    if (IN_ENB) begin
      sr_d = sr_shift;
      case (state_q)
        StHunt: begin
          // Bit-by-bit search; a hit anchors the byte and frame counters.
          if (com_hit) begin
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            good_d     = 4'd1;
            bad_d      = '0;
            state_d    = (LOCK_CNT == 1) ? StLocked : StVerify;
          end
        end
        StVerify: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (byte_done) byte_cnt_d = byte_next;
          if (frame_start) begin
            if (com_hit) begin
              good_d = good_inc;
              // The byte that completes verification is published as frame start.
              if (good_inc >= LockTh) begin
                state_d = StLocked;
                bad_d   = '0;
                lane_d  = sr_shift;
                valid_d = 1'b1;
                sof_d   = 1'b1;
              end
            end else begin
              state_d = StHunt;
              good_d  = '0;
            end
          end
        end
        StLocked: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (byte_done) begin
            byte_cnt_d = byte_next;
            if (frame_start && !com_hit && (bad_inc >= LossTh)) begin
              // Losing byte is dropped; output lanes keep their last value.
              state_d = StHunt;
              good_d  = '0;
              bad_d   = '0;
            end else begin
              if (frame_start) bad_d = com_hit ? '0 : bad_inc;
              lane_d  = sr_shift;
              valid_d = 1'b1;
              sof_d   = frame_start;
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= StHunt;
      sr_q       <= '0;
      lane_q     <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      good_q     <= '0;
      bad_q      <= '0;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      lock_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      lane_q     <= lane_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      valid_q    <= valid_d;
      sof_q      <= sof_d;
      lock_q     <= (state_d == StLocked);
    end
  end

  assign OUT_LANE0 = lane_q[0];
  assign OUT_LANE1 = lane_q[1];
  assign OUT_LANE2 = lane_q[2];
  assign OUT_LANE3 = lane_q[3];
  assign OUT_VALID = valid_q;
  assign OUT_SOF   = sof_q;
  assign OUT_LOCK  = lock_q;
  assign OUT_STATE = state_q;

endmodule

// File: tb/tb_s2p_lane_ctrl.sv
// Bench for s2p_lane_ctrl: directed lock/loss/direction/reset scenarios and
// random frames, compared every cycle against a bit-window/phase model.
module tb_s2p_lane_ctrl;

  localparam logic [7:0] COM       = 8'hBC;
  localparam int         FRAME_LEN = 16;
  localparam int         LOCK_CNT  = 4;
  localparam int         LOSS_CNT  = 4;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       IN_ENB = 1'b0;
  logic       IN_DIR = 1'b0;
  logic [3:0] IN_LANE = 4'h0;
  logic [7:0] OUT_LANE3, OUT_LANE2, OUT_LANE1, OUT_LANE0;
  logic       OUT_VALID, OUT_SOF, OUT_LOCK;
  logic [1:0] OUT_STATE;

  int checks = 0;
  int errors = 0;
  bit rnd_gaps = 1'b0;

  s2p_lane_ctrl #(
    .COM       (COM),
    .FRAME_LEN (FRAME_LEN),
    .LOCK_CNT  (LOCK_CNT),
    .LOSS_CNT  (LOSS_CNT)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .IN_ENB    (IN_ENB),
    .IN_DIR    (IN_DIR),
    .IN_LANE   (IN_LANE),
    .OUT_LANE3 (OUT_LANE3),
    .OUT_LANE2 (OUT_LANE2),
    .OUT_LANE1 (OUT_LANE1),
    .OUT_LANE0 (OUT_LANE0),
    .OUT_VALID (OUT_VALID),
    .OUT_SOF   (OUT_SOF),
    .OUT_LOCK  (OUT_LOCK),
    .OUT_STATE (OUT_STATE)
  );

  always #5 CLK = ~CLK;

  // Model: per-lane 8-bit window, m_ph = enabled bits since the COM anchor.
  int m_state = 0;
  int m_ph    = 0;
  int m_good  = 0;
  int m_bad   = 0;
  int m_win[4]  = '{0, 0, 0, 0};
  int m_lane[4] = '{0, 0, 0, 0};
  int m_valid = 0;
  int m_sof   = 0;

  task automatic model_reset();
    m_state = 0; m_ph = 0; m_good = 0; m_bad = 0; m_valid = 0; m_sof = 0;
    for (int i = 0; i < 4; i++) begin
      m_win[i] = 0;
      m_lane[i] = 0;
    end
  endtask

  task automatic publish(input int sof);
    for (int i = 0; i < 4; i++) m_lane[i] = m_win[i];
    m_valid = 1;
    m_sof = sof;
  endtask

  task automatic model_step(input bit enb, input bit dir, input logic [3:0] lanes);
    int fs, hit;
    if (!RESET) begin
      model_reset();
      return;
    end
    m_valid = 0;
    m_sof = 0;
    if (!enb) return;
    for (int i = 0; i < 4; i++) begin
      if (dir) m_win[i] = (m_win[i] >> 1) | (int'(lanes[i]) << 7);
      else     m_win[i] = ((m_win[i] << 1) | int'(lanes[i])) & 255;
    end
    hit = (m_win[0] == int'(COM)) ? 1 : 0;
    if (m_state == 0) begin
      if (hit == 1) begin
        m_ph = 0; m_good = 1; m_bad = 0;
        m_state = (LOCK_CNT == 1) ? 2 : 1;
      end
      return;
    end
    m_ph = (m_ph + 1) % (8 * FRAME_LEN);
    if (m_ph % 8 != 0) return;
    fs = (m_ph == 0) ? 1 : 0;
    if (m_state == 1) begin
      if (fs == 1 && hit == 1) begin
        m_good = (m_good + 1 > 15) ? 15 : m_good + 1;
        if (m_good >= LOCK_CNT) begin
          m_state = 2;
          m_bad = 0;
          publish(1);
        end
      end else if (fs == 1) begin
        m_state = 0;
        m_good = 0;
      end
    end else begin
      if (fs == 1) m_bad = (hit == 1) ? 0 : ((m_bad + 1 > 15) ? 15 : m_bad + 1);
      if (fs == 1 && m_bad >= LOSS_CNT) begin
        m_state = 0; m_good = 0; m_bad = 0;
      end else begin
        publish(fs);
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    check("valid", int'(OUT_VALID), m_valid);
    check("sof", int'(OUT_SOF), m_sof);
    check("state", int'(OUT_STATE), m_state);
    check("lock", int'(OUT_LOCK), (m_state == 2) ? 1 : 0);
    check("lane0", int'(OUT_LANE0), m_lane[0]);
    check("lane1", int'(OUT_LANE1), m_lane[1]);
    check("lane2", int'(OUT_LANE2), m_lane[2]);
    check("lane3", int'(OUT_LANE3), m_lane[3]);
  endtask

  // One clock: drive, let model see the edge, compare on the falling edge.
  task automatic cycle(input bit enb, input bit dir, input logic [3:0] lanes);
    IN_ENB = enb;
    IN_DIR = dir;
    IN_LANE = lanes;
    @(posedge CLK);
    model_step(enb, dir, lanes);
    @(negedge CLK);
    compare_all();
  endtask

  // One byte per lane; dir 0 sends MSB first, dir 1 LSB first.
  task automatic send_byte(input bit dir, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3,
                           input int gap_at, input bit wild);
    for (int k = 0; k < 8; k++) begin
      automatic int idx = dir ? k : 7 - k;
      automatic bit d = wild ? 1'($urandom) : dir;
      if (k == gap_at) repeat (5) cycle(1'b0, dir, 4'($urandom));
      if (rnd_gaps) while ($urandom_range(0, 4) == 0) cycle(1'b0, dir, 4'($urandom));
      cycle(1'b1, d, {b3[idx], b2[idx], b1[idx], b0[idx]});
    end
  endtask

  task automatic send_rest(input bit dir);
    for (int b = 1; b < FRAME_LEN; b++) send_byte(dir, 8'h00, 8'h11, 8'h22, 8'h33, -1, 1'b0);
  endtask

  task automatic lit_lanes(input logic [7:0] l0);
    check("lit_valid", int'(OUT_VALID), 1);
    check("lit_sof", int'(OUT_SOF), 1);
    check("lit_lane0", int'(OUT_LANE0), int'(l0));
    check("lit_lane1", int'(OUT_LANE1), 8'h11);
    check("lit_lane2", int'(OUT_LANE2), 8'h22);
    check("lit_lane3", int'(OUT_LANE3), 8'h33);
  endtask

  // Four COM frames from HUNT: VERIFY after the first, LOCKED on the fourth.
  task automatic acquire(input bit dir);
    int nstrobe = 0;
    for (int f = 0; f < 4; f++) begin
      send_byte(dir, COM, 8'h11, 8'h22, 8'h33, -1, 1'b0);
      if (f < 3) begin
        check("lit_verify_state", int'(OUT_STATE), 1);
        check("lit_verify_novalid", int'(OUT_VALID), 0);
      end else begin
        check("lit_locked_state", int'(OUT_STATE), 2);
        check("lit_locked_lock", int'(OUT_LOCK), 1);
        lit_lanes(COM);
      end
      for (int b = 1; b < FRAME_LEN; b++) begin
        send_byte(dir, 8'h00, 8'h11, 8'h22, 8'h33, -1, 1'b0);
        if (f == 3 && OUT_VALID && !OUT_SOF) nstrobe++;
      end
    end
    check("lit_strobes", nstrobe, FRAME_LEN - 1);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d errors so far", errors);
    $fatal(1);
  end

  initial begin
    #2 RESET = 1'b0;
    @(negedge CLK);
    // Held reset with random toggling, then idle after release.
    repeat (10) cycle(1'($urandom), 1'($urandom), 4'($urandom));
    RESET = 1'b1;
    repeat (5) cycle(1'b0, 1'($urandom), 4'($urandom));
    check("lit_idle_state", int'(OUT_STATE), 0);
    check("lit_idle_lane0", int'(OUT_LANE0), 0);

    acquire(1'b0);

    // Three bad COMs then a good one: stays locked with bad cleared.
    for (int f = 0; f < 3; f++) begin
      send_byte(1'b0, 8'h3C, 8'h11, 8'h22, 8'h33, -1, 1'b0);
      check("lit_badcom_state", int'(OUT_STATE), 2);
      lit_lanes(8'h3C);
      send_rest(1'b0);
    end
    send_byte(1'b0, COM, 8'h11, 8'h22, 8'h33, -1, 1'b0);
    lit_lanes(COM);
    send_rest(1'b0);

    // Four bad COMs: the fourth drops lock without a strobe.
    for (int f = 0; f < 4; f++) begin
      send_byte(1'b0, 8'h3C, 8'h11, 8'h22, 8'h33, -1, 1'b0);
      if (f < 3) lit_lanes(8'h3C);
      else begin
        check("lit_loss_lock", int'(OUT_LOCK), 0);
        check("lit_loss_valid", int'(OUT_VALID), 0);
        check("lit_loss_state", int'(OUT_STATE), 0);
        check("lit_loss_hold", int'(OUT_LANE1), 8'h11);
      end
      send_rest(1'b0);
    end

    // False COM in VERIFY returns to HUNT.
    send_byte(1'b0, COM, 8'h11, 8'h22, 8'h33, -1, 1'b0);
    check("lit_false_verify", int'(OUT_STATE), 1);
    send_rest(1'b0);
    send_byte(1'b0, 8'h00, 8'h11, 8'h22, 8'h33, -1, 1'b0);
    check("lit_false_hunt", int'(OUT_STATE), 0);
    send_rest(1'b0);

    // LSB-first lock, then a five-cycle enable gap inside a locked byte.
    acquire(1'b1);
    send_byte(1'b1, COM, 8'h11, 8'h22, 8'h33, -1, 1'b0);
    send_byte(1'b1, 8'h00, 8'h5A, 8'h22, 8'h33, 3, 1'b0);
    check("lit_gap_valid", int'(OUT_VALID), 1);
    check("lit_gap_lane1", int'(OUT_LANE1), 8'h5A);

    // Asynchronous reset at bit 4 of a locked byte, then relock.
    for (int k = 0; k < 4; k++) cycle(1'b1, 1'b1, 4'($urandom));
    #2 RESET = 1'b0;
    model_reset();
    #1;
    check("lit_async_state", int'(OUT_STATE), 0);
    check("lit_async_lock", int'(OUT_LOCK), 0);
    check("lit_async_lane1", int'(OUT_LANE1), 0);
    @(negedge CLK);
    repeat (3) cycle(1'b1, 1'b0, 4'($urandom));
    RESET = 1'b1;
    acquire(1'b0);

    // Random frames: gaps, occasional corrupted COM, random data and direction.
    rnd_gaps = 1'b1;
    for (int f = 0; f < 40; f++) begin
      automatic bit d = 1'($urandom);
      automatic logic [7:0] c = ($urandom_range(0, 5) == 0) ? 8'($urandom) : COM;
      send_byte(d, c, 8'($urandom), 8'($urandom), 8'($urandom), -1, 1'b0);
      for (int b = 1; b < FRAME_LEN; b++)
        send_byte(d, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), -1,
                  ($urandom_range(0, 9) == 0));
    end
    rnd_gaps = 1'b0;
    repeat (300) cycle(1'($urandom), 1'($urandom), 4'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
